// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
//
// Instruction-fetch front end. It holds the program counter and issues one
// request at a time to instruction memory. Each returned word is presented
// to decode together with its PC, and decode can hold it with a stall.
// Branch and jump redirects from later stages replace the sequential PC+STEP
// path.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   Defined   : a redirect to a target whose low two bits are non-zero parks
//               the unit in HALTED. It also raises a sticky `misalign` flag
//               and leaves pc unchanged.
//   Undefined : targets are used as given and `misalign` is tied low.
//
// Parameters
//   RESET_PC      PC loaded on reset
//   PC_STEP       sequential increment
//
// Ports
//   clk           rising-edge clock
//   rst           synchronous active-high reset
//   stall         decode cannot accept the presented instruction
//   branch_taken  redirect to branch_target
//   branch_target branch destination
//   jump          redirect to jump_target (wins over branch)
//   jump_target   jump destination
//   halt          stop fetching, sticky until reset
//   imem_req      fetch request, held until imem_ack
//   imem_addr     fetch address (current pc)
//   imem_ack      memory returns data this cycle
//   imem_rdata    instruction word, valid with imem_ack
//   if_valid      if_pc/if_instr hold a valid instruction
//   if_pc         PC of the presented instruction
//   if_instr      presented instruction word
//   halted        unit is in HALTED
//   misalign      misaligned redirect seen (alignment check builds only)
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic        misalign
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_REQ    = 2'd1;
  localparam logic [1:0] ST_VALID  = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_instr_q, if_instr_d;

  logic        redirect;
  logic [31:0] redirect_target;
  logic        target_misaligned;

  // Jump outranks branch when both arrive in the same cycle.
  always_comb begin
    redirect        = jump | branch_taken;
    redirect_target = jump ? jump_target : branch_target;
  end

`ifdef PC_ALIGN_CHECK_EN
  always_comb begin
    target_misaligned = (redirect_target[1:0] != 2'b00);
  end
`else
  always_comb begin
    target_misaligned = 1'b0;
  end
`endif

  // Next-state logic. The order of tests gives the priority
  // halt > redirect > ack > stall. A redirect in REQ overrides a
  // simultaneous ack, so that ack's data is dropped. A redirect in VALID
  // flushes the presented word even while stalled.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_pc_d    = if_pc_q;
    if_instr_d = if_instr_q;
    if (state_q != ST_HALTED) begin
      if (halt) begin
        state_d = ST_HALTED;
      end else if (redirect) begin
        if (target_misaligned) begin
          state_d = ST_HALTED;
        end else begin
          pc_d    = redirect_target;
          state_d = ST_REQ;
        end
      end else begin
        case (state_q)
          ST_IDLE: state_d = ST_REQ;
          ST_REQ: begin
            if (imem_ack) begin
              if_instr_d = imem_rdata;
              if_pc_d    = pc_q;
              pc_d       = pc_q + PC_STEP;
              state_d    = ST_VALID;
            end
          end
          ST_VALID: begin
            if (!stall) begin
              state_d = ST_REQ;
            end
          end
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      if_pc_q    <= 32'h0;
      if_instr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_pc_q    <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  // Sticky flag. It sets only when a misaligned redirect actually takes
  // effect, meaning the unit is not already halted and no halt is pending.
  always_comb begin
    misalign_d = misalign_q |
                 ((state_q != ST_HALTED) && !halt && redirect && target_misaligned);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

  // Moore outputs: decoded from state or driven straight from flops.
  assign imem_req  = (state_q == ST_REQ);
  assign imem_addr = pc_q;
  assign if_valid  = (state_q == ST_VALID);
  assign halted    = (state_q == ST_HALTED);
  assign if_pc     = if_pc_q;
  assign if_instr  = if_instr_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
//
// Self-checking bench for pc_fetch_unit. A behavioural model tracks the fetch
// front end as a few flags: stopped, fetching and presenting. Directed
// scenarios run first, followed by a long randomized run. Inputs change on
// the falling edge. At the next falling edge the model absorbs those inputs
// and every output is compared against it.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'h0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic        misalign;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state.
  logic [31:0] mPc;
  logic [31:0] mIfPc;
  logic [31:0] mIfInstr;
  bit          mStopped;
  bit          mFetching;
  bit          mPresenting;
  bit          mMisalign;

  pc_fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .halt         (halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .if_instr     (if_instr),
    .halted       (halted),
    .misalign     (misalign)
  );

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the inputs the clock edge just sampled to the model. Only one
  // rule fires per cycle, chosen in priority order.
  task automatic modelStep();
    logic [31:0] tgt;
    bit          bad;
    tgt = jump ? jump_target : branch_target;
`ifdef PC_ALIGN_CHECK_EN
    bad = (tgt % 4) != 0;
`else
    bad = 1'b0;
`endif
    if (rst) begin
      mPc = RESET_PC; mIfPc = 0; mIfInstr = 0;
      mStopped = 0; mFetching = 0; mPresenting = 0; mMisalign = 0;
    end else if (mStopped) begin
      // Only reset leaves the stopped condition.
    end else if (halt) begin
      mStopped = 1; mFetching = 0; mPresenting = 0;
    end else if (jump || branch_taken) begin
      mPresenting = 0;
      if (bad) begin
        mStopped = 1; mFetching = 0; mMisalign = 1;
      end else begin
        mPc = tgt; mFetching = 1;
      end
    end else if (mFetching) begin
      if (imem_ack) begin
        mIfInstr = imem_rdata; mIfPc = mPc; mPc = mPc + PC_STEP;
        mFetching = 0; mPresenting = 1;
      end
    end else if (mPresenting) begin
      if (!stall) begin
        mPresenting = 0; mFetching = 1;
      end
    end else begin
      mFetching = 1;
    end
  endtask

  // Drive one cycle of inputs, let the clock edge act on them, then
  // compare every output against the model.
  task automatic applyStimulus(input bit r, input bit s, input bit b, input logic [31:0] bt,
                               input bit j, input logic [31:0] jt, input bit h,
                               input bit a, input logic [31:0] rd);
    rst = r; stall = s; branch_taken = b; branch_target = bt;
    jump = j; jump_target = jt; halt = h; imem_ack = a; imem_rdata = rd;
    @(negedge clk);
    modelStep();
    checkOutput("imem_req", 32'(imem_req), 32'(mFetching));
    checkOutput("imem_addr", imem_addr, mPc);
    checkOutput("if_valid", 32'(if_valid), 32'(mPresenting));
    checkOutput("if_pc", if_pc, mIfPc);
    checkOutput("if_instr", if_instr, mIfInstr);
    checkOutput("halted", 32'(halted), 32'(mStopped));
    checkOutput("misalign", 32'(misalign), 32'(mMisalign));
  endtask

  function automatic logic [31:0] randTarget();
    if ($urandom_range(0, 3) == 0) return $urandom;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  initial begin
    @(negedge clk);

    // Reset state.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    checkOutput("rst_addr", imem_addr, RESET_PC);
    checkOutput("rst_req", 32'(imem_req), 32'd0);

    // Memory acks every cycle: if_pc runs 0, 4, 8, 12 and a word is
    // presented on alternate cycles.
    for (int i = 0; i < 8; i++)
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1000_0000 + 32'(i));
    checkOutput("seq_if_pc", if_pc, 32'd12);

    // Hold a presented word with stall for three cycles, then release it.
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, $urandom);
    checkOutput("stall_if_pc", if_pc, 32'd12);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("stall_next_addr", imem_addr, 32'd16);

    // A jump and a branch arrive together with an ack. The jump wins and
    // the ack is discarded.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 32'h200, 1, 32'h100, 0, 1, 32'hCAFE_F00D);
    checkOutput("jmp_addr", imem_addr, 32'h100);
    checkOutput("jmp_valid", 32'(if_valid), 32'd0);

    // The sequential step after the top word wraps to zero.
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h1234_5678);
    checkOutput("wrap_addr", imem_addr, 32'h0);
    checkOutput("wrap_if_pc", if_pc, 32'hFFFF_FFFC);

    // Halt during a request, followed by late acks, then reset.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 32'h5555_AAAA);
    applyStimulus(0, 0, 0, 0, 1, 32'h40, 0, 1, 32'h5555_AAAA);
    checkOutput("halt_flag", 32'(halted), 32'd1);
    checkOutput("halt_req", 32'(imem_req), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_rst_addr", imem_addr, RESET_PC);

    // A misaligned jump target.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h102, 0, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    checkOutput("mis_flag", 32'(misalign), 32'd1);
    checkOutput("mis_halted", 32'(halted), 32'd1);
    checkOutput("mis_addr", imem_addr, RESET_PC);
`else
    checkOutput("mis_flag", 32'(misalign), 32'd0);
    checkOutput("mis_addr", imem_addr, 32'h102);
`endif

    // Randomized traffic, with occasional resets to recover from halts.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 49) == 0,
                    $urandom_range(0, 2) == 0,
                    $urandom_range(0, 9) == 0, randTarget(),
                    $urandom_range(0, 11) == 0, randTarget(),
                    $urandom_range(0, 99) == 0,
                    $urandom_range(0, 1) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Instruction-fetch front end for the MIPS datapath. Holds the program counter, issues fetch requests to instruction memory and presents each fetched instruction with its PC to decode under a stall handshake. It computes the sequential PC+4 path and applies branch/jump redirects from later stages. It is the stage directly upstream of the 32-bit adder stage, which receives `if_pc` as an operand.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `PC_STEP`, default 32'd4: sequential increment.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `stall`  in  1  decode cannot accept; holds the presented instruction.
- `branch_taken`  in  1  redirect to `branch_target`.
- `branch_target`  in  32  branch destination.
- `jump`  in  1  redirect to `jump_target`; has priority over branch.
- `jump_target`  in  32  jump destination.
- `halt`  in  1  stop fetching; sticky until reset.
- `imem_req`  out  1  fetch request, held until `imem_ack`.
- `imem_addr`  out  32  fetch address; equals current PC.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word, valid with `imem_ack`.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a valid instruction.
- `if_pc`  out  32  PC of the presented instruction.
- `if_instr`  out  32  presented instruction word.
- `halted`  out  1  unit is in HALTED.
- `misalign`  out  1  misaligned redirect detected (see Configuration).

## Operation
- FSM states: IDLE, REQ, VALID, HALTED.
- IDLE: entered on reset; no request. Next cycle goes to REQ.
- REQ: `imem_req`=1, `imem_addr`=pc.
  - On `imem_ack`: capture `if_instr`<=`imem_rdata` and `if_pc`<=pc, then pc<=pc+`PC_STEP`. Go to VALID.
  - Without ack: stay in REQ and hold the address.
- VALID: `if_valid`=1, `imem_req`=0. An instruction is consumed in a cycle where `if_valid`=1 and `stall`=0; the unit then goes to REQ. While `stall`=1 it stays in VALID with outputs frozen.
- Redirect (`jump` or `branch_taken`) in IDLE, REQ or VALID:
  - pc<=target (`jump_target` if `jump`, else `branch_target`).
  - `if_valid`<=0, which flushes the presented instruction regardless of `stall`.
  - Next state is REQ. An `imem_ack` arriving in the same cycle is discarded.
- `halt`=1 in any state: next state is HALTED. In HALTED, `imem_req`=0, `if_valid`=0 and `halted`=1; pc is frozen. The unit exits HALTED only through `rst`.
- Priority, highest first: `rst` > `halt` > `jump` > `branch_taken` > `imem_ack` > `stall`.
- Arithmetic is unsigned 32-bit modulo 2^32: pc 32'hFFFF_FFFC + 4 wraps to 32'h0000_0000 with no flag.
- `imem_ack` is ignored while `imem_req`=0.

## Timing
- Reset values: pc=`RESET_PC`, state=IDLE, `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_pc`=0, `if_instr`=0, `halted`=0, `misalign`=0.
- All outputs are registered or decoded from state (Moore). No input-to-output combinational path.
- First request is asserted 1 cycle after reset is released.
- Ack in cycle N gives `if_valid`=1 in cycle N+1.
- With an immediate ack and no stall, throughput is one instruction per 2 cycles.
- A redirect sampled in cycle N gives `imem_addr`=target with `imem_req`=1 in cycle N+1.
- `rst` asserted mid-request abandons the request; a late `imem_ack` after reset is ignored unless the unit is in REQ.

## Configuration
- Macro `PC_ALIGN_CHECK_EN`.
- Defined:
  - A redirect whose target has [1:0]≠0 sends the unit to HALTED.
  - `misalign`=1 (sticky until reset); pc is not updated.
  - `halted`=1.
- Undefined: targets are used unmodified and `misalign` is tied 0.

## Test plan
- Reset with `RESET_PC`=0, memory acking every request → `if_pc` sequence 0, 4, 8, 12; `if_valid` high on alternate cycles.
- Hold `stall`=1 for 3 cycles while `if_valid`=1 → `if_instr`/`if_pc` stable; no `imem_req`; after release, next fetch at PC+4.
- Assert `jump`=1 (`jump_target`=32'h100) and `branch_taken`=1 (`branch_target`=32'h200) in the same cycle as an ack → ack discarded; `if_valid`=0; next `imem_addr`=32'h100.
- `branch_target`=32'hFFFF_FFFC, then sequential fetch → next `imem_addr`=0.
- Assert `halt` during REQ with a late ack → `halted`=1; no further requests; ack ignored; `rst` restores `RESET_PC`.
- With `PC_ALIGN_CHECK_EN` defined, `jump_target`=32'h102 → `misalign`=1, `halted`=1, pc unchanged. With the macro undefined → `imem_addr`=32'h102.
